fullsub_seq: RTL

//   Parametrised multi-cycle subtractor. Computes diff = a - b - bin over WIDTH bits.

---
 rtl/fullsub_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fullsub_seq.sv
// +----------------------------------------------------------------------------+
// | fullsub_seq : multi-cycle a - b - bin subtractor, CHUNK bits per clock,     |
// |               borrow carried in a register. Optional: `SUB_FLAGS_EN.        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fullsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("fullsub_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_d;
  logic             chunk_br;
  logic [WIDTH-1:0] res_next;

  // One chunk of ripple full-subtractor cells; borrow enters from the register.
  always_comb begin
    logic br;
    chunk_a = a_r[int'(cnt)*CHUNK +: CHUNK];
    chunk_b = b_r[int'(cnt)*CHUNK +: CHUNK];
    chunk_d = '0;
    br      = br_r;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_d[i] = chunk_a[i] ^ chunk_b[i] ^ br;
      br         = (~chunk_a[i] & chunk_b[i]) | (~(chunk_a[i] ^ chunk_b[i]) & br);
    end
    chunk_br = br;
    res_next = res_r;
    res_next[int'(cnt)*CHUNK +: CHUNK] = chunk_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      br_r  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_FLAGS_EN
      ovf   <= 1'b0;
      zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            br_r  <= bin;
            res_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_r <= res_next;
          br_r  <= chunk_br;
          if (cnt == LAST) begin
            // Published results only move here, so they hold through IDLE and RUN.
            diff  <= res_next;
            bout  <= chunk_br;
`ifdef SUB_FLAGS_EN
            ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (res_next[WIDTH-1] ^ a_r[WIDTH-1]);
            zero  <= (res_next == '0);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
